func_type1_stream: RTL
======================

# func_type1_stream

Parametrised, streaming successor to the combinational type-1 special-node function in the polar SC decoder. It accepts a node's LLRs over one or more beats with a valid/ready handshake and accumulates per-group signed sums across beats. It then makes hard decisions and replays the repeated decision pattern as an output bit stream with the same beat count. It sits between the LLR process unit and the partial-sum/bit-output path. It supports both repetition mode (one group) and type-1 mode (interleaved groups).

## Interface
- LLR_W, 6: signed two's-complement width of one LLR.
- LANES, 8: LLRs per input beat; must be a multiple of GROUPS.
- GROUPS, 2: interleave groups in type-1 mode; power of 2.
- MAX_BEATS, 8: maximum beats per node.
- Derived: ACC_W = LLR_W + clog2(LANES*MAX_BEATS); CNT_W = clog2(MAX_BEATS+1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_first  in  1  beat is the first of a node.
- in_last  in  1  beat is the last of a node.
- mode  in  1  0 = repetition (single sum), 1 = type-1 (GROUPS sums); sampled on the first beat.
- llr_in  in  LANES*LLR_W  lane 0 at bits [LANES*LLR_W-1 -: LLR_W], lane k below lane k-1.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_bits  out  LANES  bit for lane k at bit LANES-1-k.
- out_last  out  1  final output beat of the node.
- dec_bits  out  GROUPS  registered decisions; bit GROUPS-1-g belongs to group g.

## Operation
- The FSM has three states: S_ACC, S_DEC and S_OUT. Reset enters S_ACC.
- Lane k belongs to group g = k mod GROUPS. Each LLR is sign-extended to ACC_W before any addition.
- **S_ACC** (in_ready = 1):
  - On each handshake, acc[g] += sum of that group's lanes, and cnt increments.
  - The first beat of a node is the first beat after reset or S_OUT, or any beat with in_first = 1. That beat loads acc from its own lane sums instead of adding, sets cnt = 1 and latches mode.
  - An in_first beat arriving mid-node discards the partial node and restarts.
  - A beat with in_last = 1, or the beat that brings cnt to MAX_BEATS, ends accumulation and moves the FSM to S_DEC.
- **S_DEC** (one cycle):
  - mode = 1: dec_bits[g] = sign bit of acc[g].
  - mode = 0: every group's decision = sign of the sum of all acc[g].
  - A sum of exactly zero decides 0.
  - The FSM then moves to S_OUT with the output beat counter = cnt.
- **S_OUT**:
  - out_valid = 1; out_bits lane k = decision of group k mod GROUPS.
  - out_last = 1 on the final beat.
  - Each out_valid & out_ready handshake decrements the counter. The handshake on the out_last beat returns the FSM to S_ACC, clears out_valid and clears acc and cnt.
  - In S_OUT, out_bits and out_last are held while out_ready = 0.
- **Arithmetic:** ACC_W is sized so that MAX_BEATS beats of all-minimum LLRs cannot overflow; no saturation logic is needed.
- **Reset values:** in_ready = 1, out_valid = 0, out_bits = 0, out_last = 0, dec_bits = 0, acc = 0, cnt = 0.
- **Reset mid-node or mid-output:** all state is abandoned immediately and no further output beat is produced.

## Timing
- The final input handshake occurs at edge t. S_DEC occupies t..t+1. out_valid is first high after edge t+2, giving 2-cycle latency.
- in_ready is 0 from the cycle after the last input handshake until the cycle after the last output handshake.
- The next node's first beat is therefore accepted at the earliest one cycle after the out_last handshake.
- An N-beat node with no backpressure costs N + 2 + N cycles.
- dec_bits is valid from S_OUT entry and stable until the next S_DEC.
- in_valid is ignored outside S_ACC.

## Test plan
All scenarios use the defaults (LLR_W=6, LANES=8, GROUPS=2, MAX_BEATS=8).
- **Single-beat type-1:** mode=1; even lanes +3, odd lanes -2; first = last = 1 → dec_bits = 2'b01, one beat out_bits = 8'h55 with out_last = 1, out_valid 2 cycles after the input handshake.
- **Repetition vs type-1:** even lanes +5, odd lanes -4. mode=0 → total +4, out_bits = 8'h00. Same data with mode=1 → out_bits = 8'h55.
- **Full depth, worst case:** 8 beats of all -32 with mode=1 → each acc = -1024 with no wrap. Exactly 8 output beats of 8'hFF, out_last only on the 8th. Repeat with in_last never asserted → the node still ends at beat 8.
- **Zero sum:** 2 beats, beat 1 all +7, beat 2 all -7 → dec_bits = 0, two beats of 8'h00.
- **Backpressure:** 3-beat node; hold out_ready low for 4 cycles mid-output → out_bits and out_last are stable, in_ready = 0 throughout, and exactly 3 beats are delivered.
- **Restart and reset:**
  - Send 2 beats of +10, then an in_first beat of all -1 with in_last → single output 8'hFF.
  - Assert rst during S_OUT → out_valid = 0 and in_ready = 1 immediately, and no stale beats appear afterwards.

Source files
------------

// File: rtl/func_type1_stream.sv
// Streaming type-1 / repetition special-node decoder: accumulates per-group LLR sums over
// one or more input beats, makes hard decisions, then replays the decision pattern per beat.
module func_type1_stream #(
    parameter int LLR_W     = 6,
    parameter int LANES     = 8,
    parameter int GROUPS    = 2,
    parameter int MAX_BEATS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic                   mode,
    input  logic [LANES*LLR_W-1:0] llr_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       out_bits,
    output logic                   out_last,
    output logic [GROUPS-1:0]      dec_bits
);

    localparam int ACC_W = LLR_W + $clog2(LANES * MAX_BEATS);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam int LPG   = LANES / GROUPS;

    typedef enum logic [1:0] {
        S_ACC = 2'd0,
        S_DEC = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic signed [ACC_W-1:0] acc_reg [GROUPS];
    logic [CNT_W-1:0]        cnt_reg;
    logic [CNT_W-1:0]        out_cnt_reg;
    logic                    mode_reg;
    logic [GROUPS-1:0]       dec_bits_reg;
    logic                    out_valid_reg;
    logic                    out_last_reg;
    logic [LANES-1:0]        out_bits_reg;

    logic signed [LLR_W-1:0] lane [LANES];
    logic signed [ACC_W-1:0] beat_sum [GROUPS];
    logic signed [ACC_W-1:0] total;
    logic [GROUPS-1:0]       dec_next;
    logic [LANES-1:0]        pattern;
    logic [CNT_W-1:0]        cnt_step;
    logic                    start_node;
    logic                    in_fire;
    logic                    out_fire;

    genvar gi;

    // Lane 0 occupies the most significant slot of the input word.
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane[gi] = llr_in[(LANES-gi)*LLR_W-1 -: LLR_W];
        end
    endgenerate

    generate
        for (gi = 0; gi < GROUPS; gi++) begin : g_grp
            logic signed [ACC_W-1:0] gsum;
            always_comb begin
                gsum = '0;
                for (int j = 0; j < LPG; j++) begin
                    gsum = gsum + {{(ACC_W-LLR_W){lane[j*GROUPS+gi][LLR_W-1]}}, lane[j*GROUPS+gi]};
                end
            end
            assign beat_sum[gi] = gsum;
        end
    endgenerate

    // Output lane k repeats the decision of its interleave group.
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_pat
            assign pattern[LANES-1-gi] = dec_bits_reg[GROUPS-1-(gi % GROUPS)];
        end
    endgenerate

    always_comb begin
        total = '0;
        for (int g = 0; g < GROUPS; g++) begin
            total = total + acc_reg[g];
        end
        dec_next = '0;
        for (int g = 0; g < GROUPS; g++) begin
            dec_next[GROUPS-1-g] = mode_reg ? acc_reg[g][ACC_W-1] : total[ACC_W-1];
        end
    end

    // A cleared beat count marks the start of a fresh node.
    assign start_node = in_first || (cnt_reg == '0);
    assign cnt_step   = start_node ? CNT_W'(1) : cnt_reg + CNT_W'(1);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid_reg && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_ACC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        case (state_reg)
            S_ACC: begin
                in_ready = 1'b1;
                if (in_valid && (in_last || cnt_step == CNT_W'(MAX_BEATS))) begin
                    state_next = S_DEC;
                end
            end
            S_DEC: begin
                state_next = S_OUT;
            end
            S_OUT: begin
                if (out_fire && out_last_reg) begin
                    state_next = S_ACC;
                end
            end
            default: begin
                state_next = S_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < GROUPS; g++) begin
                acc_reg[g] <= '0;
            end
            cnt_reg       <= '0;
            out_cnt_reg   <= '0;
            mode_reg      <= 1'b0;
            dec_bits_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_bits_reg  <= '0;
        end else begin
            case (state_reg)
                S_ACC: begin
                    if (in_fire) begin
                        for (int g = 0; g < GROUPS; g++) begin
                            acc_reg[g] <= start_node ? beat_sum[g] : acc_reg[g] + beat_sum[g];
                        end
                        cnt_reg <= cnt_step;
                        if (start_node) begin
                            mode_reg <= mode;
                        end
                    end
                end
                S_DEC: begin
                    dec_bits_reg <= dec_next;
                    out_cnt_reg  <= cnt_reg;
                end
                S_OUT: begin
                    // First S_OUT cycle loads the output registers; afterwards they only
                    // move on a handshake, so they hold under backpressure.
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                        out_bits_reg  <= pattern;
                        out_last_reg  <= (out_cnt_reg == CNT_W'(1));
                    end else if (out_ready) begin
                        if (out_last_reg) begin
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            cnt_reg       <= '0;
                            for (int g = 0; g < GROUPS; g++) begin
                                acc_reg[g] <= '0;
                            end
                        end else begin
                            out_cnt_reg  <= out_cnt_reg - CNT_W'(1);
                            out_last_reg <= (out_cnt_reg == CNT_W'(2));
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_bits  = out_bits_reg;
    assign out_last  = out_last_reg;
    assign dec_bits  = dec_bits_reg;

endmodule
